// File: rtl/ntt_host_pkg.sv
// Shared sizes and sequencer state encoding for the ntt host loader.
package ntt_host_pkg;

   localparam int LANES  = 257;
   localparam int ROWS   = 85;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 8;
   localparam int RD_LAT = 2;

   localparam int COL_W  = 9;
   localparam int ROW_W  = 7;
   localparam int LAT_W  = 2;
   localparam int MOD_W  = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_WRITE   = 3'd2,
      ST_TRIGGER = 3'd3,
      ST_WAIT    = 3'd4,
      ST_RDREQ   = 3'd5,
      ST_CAPTURE = 3'd6,
      ST_DRAIN   = 3'd7
   } state_t;

endpackage

// File: rtl/ntt_row_buffer.sv
// One ntt row of coefficients: word-wise fill/drain by column, whole-row
// load from the ntt read port and whole-row presentation to its write port.
module ntt_row_buffer
   import ntt_host_pkg::*;
#(
   parameter int NUM_LANES = LANES
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          word_wr,
   input  logic [COL_W-1:0]              wr_col,
   input  logic [WORD_W-1:0]             wr_data,
   input  logic                          row_load,
   input  logic [WORD_W*NUM_LANES-1:0]   load_data,
   input  logic [COL_W-1:0]              rd_col,
   output logic [WORD_W-1:0]             rd_data,
   output logic [WORD_W*NUM_LANES-1:0]   row_data
);

   logic [WORD_W*NUM_LANES-1:0] row_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_q <= '0;
      end else if (row_load) begin
         row_q <= load_data;
      end else if (word_wr) begin
         row_q[int'(wr_col)*WORD_W +: WORD_W] <= wr_data;
      end
   end

   assign rd_data  = row_q[int'(rd_col)*WORD_W +: WORD_W];
   assign row_data = row_q;

endmodule

// File: rtl/ntt_host_loader.sv
// Sequencer that streams a polynomial into the ntt row memory, starts the
// transform, waits for a fresh done edge and streams the rows back out.
//
// state   | meaning
// IDLE    | waiting for go
// LOAD    | accepting input words into the row buffer
// WRITE   | one-cycle row write into ntt
// TRIGGER | one-cycle ntt start pulse
// WAIT    | waiting for a 0->1 edge of ntt_done
// RDREQ   | row read issued, counting read latency
// CAPTURE | latching ntt_dout into the row buffer
// DRAIN   | presenting the buffered row on the output stream
module ntt_host_loader
   import ntt_host_pkg::*;
#(
   parameter int NUM_LANES = LANES,
   parameter int NUM_ROWS  = ROWS
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          go,
   input  logic [MOD_W-1:0]              mod_idx_in,
   output logic                          busy,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [WORD_W-1:0]             s_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [WORD_W-1:0]             m_data,
   output logic                          m_last,
   output logic                          ntt_start,
   output logic [MOD_W-1:0]              ntt_mod_idx,
   output logic                          ntt_mem_write,
   output logic                          ntt_mem_read,
   output logic [ADDR_W*NUM_LANES-1:0]   ntt_mem_addr,
   output logic [WORD_W*NUM_LANES-1:0]   ntt_din,
   input  logic [WORD_W*NUM_LANES-1:0]   ntt_dout,
   input  logic                          ntt_done
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_LANES - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

   state_t                      state_q, state_d;
   logic [COL_W-1:0]            col_q;
   logic [ROW_W-1:0]            row_q;
   logic [LAT_W-1:0]            lat_q;
   logic [MOD_W-1:0]            mod_q;
   logic                        done_prev_q;
   logic                        wait_first_q;

   logic                        in_hs;
   logic                        col_end;
   logic                        row_end;
   logic                        lat_end;
   logic                        done_rise;
   logic [ADDR_W-1:0]           row_addr;
   logic [WORD_W-1:0]           buf_word;
   logic [WORD_W*NUM_LANES-1:0] buf_row;

   assign in_hs     = (state_q == ST_LOAD) && s_valid;
   assign col_end   = (col_q == COL_LAST);
   assign row_end   = (row_q == ROW_LAST);
   assign lat_end   = (lat_q == LAT_LAST);
   assign row_addr  = ADDR_W'(row_q);
   // A done level left high from an earlier job never counts; only a new edge does.
   assign done_rise = ntt_done && !done_prev_q && !wait_first_q;

   ntt_row_buffer #(
      .NUM_LANES (NUM_LANES)
   ) u_row_buffer (
      .clk       (clk),
      .reset_n   (reset_n),
      .word_wr   (in_hs),
      .wr_col    (col_q),
      .wr_data   (s_data),
      .row_load  (state_q == ST_CAPTURE),
      .load_data (ntt_dout),
      .rd_col    (col_q),
      .rd_data   (buf_word),
      .row_data  (buf_row)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (go) state_d = ST_LOAD;
         ST_LOAD:    if (s_valid && col_end) state_d = ST_WRITE;
         ST_WRITE:   state_d = row_end ? ST_TRIGGER : ST_LOAD;
         ST_TRIGGER: state_d = ST_WAIT;
         ST_WAIT:    if (done_rise) state_d = ST_RDREQ;
         ST_RDREQ:   if (lat_end) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_DRAIN;
         ST_DRAIN:   if (m_ready && col_end) state_d = row_end ? ST_IDLE : ST_RDREQ;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q        <= '0;
         row_q        <= '0;
         lat_q        <= '0;
         mod_q        <= '0;
         done_prev_q  <= 1'b0;
         wait_first_q <= 1'b0;
      end else begin
         done_prev_q  <= ntt_done;
         wait_first_q <= (state_q == ST_TRIGGER);
         case (state_q)
            ST_IDLE: begin
               if (go) begin
                  mod_q <= mod_idx_in;
                  col_q <= '0;
                  row_q <= '0;
               end
            end
            ST_LOAD: begin
               if (s_valid) col_q <= col_end ? '0 : col_q + COL_W'(1);
            end
            ST_WRITE: begin
               row_q <= row_end ? '0 : row_q + ROW_W'(1);
            end
            ST_WAIT: begin
               lat_q <= '0;
            end
            ST_RDREQ: begin
               lat_q <= lat_end ? '0 : lat_q + LAT_W'(1);
            end
            ST_CAPTURE: begin
               col_q <= '0;
            end
            ST_DRAIN: begin
               if (m_ready) begin
                  if (col_end) begin
                     col_q <= '0;
                     row_q <= row_end ? '0 : row_q + ROW_W'(1);
                  end else begin
                     col_q <= col_q + COL_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      s_ready       = 1'b0;
      m_valid       = 1'b0;
      m_data        = '0;
      m_last        = 1'b0;
      ntt_start     = 1'b0;
      ntt_mem_write = 1'b0;
      ntt_mem_read  = 1'b0;
      ntt_mem_addr  = '0;
      ntt_din       = '0;
      case (state_q)
         ST_LOAD: s_ready = 1'b1;
         ST_WRITE: begin
            ntt_mem_write = 1'b1;
            ntt_mem_addr  = {NUM_LANES{row_addr}};
            ntt_din       = buf_row;
         end
         ST_TRIGGER: ntt_start = 1'b1;
         ST_RDREQ: begin
            ntt_mem_read = 1'b1;
            ntt_mem_addr = {NUM_LANES{row_addr}};
         end
         ST_DRAIN: begin
            m_valid = 1'b1;
            m_data  = buf_word;
            m_last  = row_end && col_end;
         end
         default: ;
      endcase
   end

   assign busy        = (state_q != ST_IDLE);
   assign ntt_mod_idx = mod_q;

endmodule

// File: tb/tb_ntt_host_loader.sv
// Scoreboard bench for ntt_host_loader against a behavioural ntt stub
// (row memory, done 20 cycles after start, transform = +1 mod q). Short 9-row jobs.
module tb_ntt_host_loader;
   import ntt_host_pkg::*;

   localparam int LN = 257;
   localparam int RW = 9;
   localparam int N  = LN * RW;
   localparam int DW = WORD_W * LN;
   localparam int AW = ADDR_W * LN;
   localparam logic [WORD_W-1:0] Q = 32'hFFFF_FFF1;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic              last;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              go = 1'b0;
   logic [MOD_W-1:0]  mod_idx_in = '0;
   logic              busy;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [WORD_W-1:0] s_data = '0;
   logic              m_valid;
   logic              m_ready = 1'b1;
   logic [WORD_W-1:0] m_data;
   logic              m_last;
   logic              ntt_start;
   logic [MOD_W-1:0]  ntt_mod_idx;
   logic              ntt_mem_write;
   logic              ntt_mem_read;
   logic [AW-1:0]     ntt_mem_addr;
   logic [DW-1:0]     ntt_din;
   logic [DW-1:0]     ntt_dout;
   logic              ntt_done;

   int tests = 0;
   int fails = 0;

   ntt_host_loader #(
      .NUM_LANES (LN),
      .NUM_ROWS  (RW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .go            (go),
      .mod_idx_in    (mod_idx_in),
      .busy          (busy),
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_last        (m_last),
      .ntt_start     (ntt_start),
      .ntt_mod_idx   (ntt_mod_idx),
      .ntt_mem_write (ntt_mem_write),
      .ntt_mem_read  (ntt_mem_read),
      .ntt_mem_addr  (ntt_mem_addr),
      .ntt_din       (ntt_din),
      .ntt_dout      (ntt_dout),
      .ntt_done      (ntt_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WORD_W-1:0] inc_mod(input logic [WORD_W-1:0] d);
      logic [WORD_W:0] t;
      t = ({1'b0, d} + 33'd1) % {1'b0, Q};
      return t[WORD_W-1:0];
   endfunction

   function automatic logic [DW-1:0] xform(input logic [DW-1:0] r);
      logic [DW-1:0] o;
      o = '0;
      for (int c = 0; c < LN; c++) o[c*WORD_W +: WORD_W] = inc_mod(r[c*WORD_W +: WORD_W]);
      return o;
   endfunction

   function automatic logic [WORD_W-1:0] data_of(input int job, input int i);
      if (job == 1) return WORD_W'(i);
      if (i == 5) return Q - 32'd1;
      return WORD_W'(i) * 32'h9E37_79B1 + WORD_W'(job);
   endfunction

   function automatic bit addr_is(input logic [AW-1:0] a, input int r);
      for (int k = 0; k < LN; k++) if (a[k*ADDR_W +: ADDR_W] !== ADDR_W'(r)) return 1'b0;
      return 1'b1;
   endfunction

   // ntt stub: row memory, 2-cycle read valid only for the read that follows a mem_read rise
   logic [DW-1:0] mem [RW];
   logic [DW-1:0] rd_pipe;
   logic [DW-1:0] dout_r = '0;
   logic          mr_prev = 1'b0;
   logic          rd_rise_d = 1'b0;
   logic          done_r = 1'b0;
   logic          done_fresh = 1'b0;
   logic          done_hold = 1'b0;
   int            st_cnt = 0;

   assign ntt_dout = dout_r;
   assign ntt_done = done_r;

   always @(posedge clk) begin
      mr_prev   <= ntt_mem_read;
      rd_rise_d <= ntt_mem_read && !mr_prev;
      if (ntt_mem_read && !mr_prev && int'(ntt_mem_addr[ADDR_W-1:0]) < RW)
         rd_pipe <= mem[int'(ntt_mem_addr[ADDR_W-1:0])];
      dout_r <= rd_rise_d ? rd_pipe : {LN{32'hDEAD_BEEF}};
      if (ntt_mem_write && int'(ntt_mem_addr[ADDR_W-1:0]) < RW)
         mem[int'(ntt_mem_addr[ADDR_W-1:0])] <= ntt_din;
      if (ntt_start) begin
         st_cnt     <= 1;
         done_r     <= done_hold;
         done_fresh <= 1'b0;
      end else if (st_cnt != 0) begin
         if (st_cnt == 10) done_r <= 1'b0;
         if (st_cnt == 20) begin
            for (int r = 0; r < RW; r++) mem[r] <= xform(mem[r]);
            done_r     <= 1'b1;
            done_fresh <= 1'b1;
            st_cnt     <= 0;
         end else begin
            st_cnt <= st_cnt + 1;
         end
      end
   end

   // monitor / scoreboard
   exp_t              exp_q[$];
   exp_t              e_pop;
   int                wr_row = 0, rd_row = 0, start_cnt = 0, last_cnt = 0, out_beats = 0;
   logic [MOD_W-1:0]  cur_mod = '0;
   bit                prev_wr = 0, prev_rd = 0, prev_st = 0;
   bit                pend_idle = 0, hold_pend = 0;
   logic [WORD_W-1:0] hold_data = '0;
   bit                rand_ready = 0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (ntt_mem_write) begin
            chk("write_addr", 64'(addr_is(ntt_mem_addr, wr_row)), 64'd1);
            chk("write_pulse_len", 64'(prev_wr), 64'd0);
            chk("write_read_exclusive", 64'(ntt_mem_read), 64'd0);
            wr_row++;
         end
         if (ntt_mem_read && !prev_rd) begin
            chk("read_addr", 64'(addr_is(ntt_mem_addr, rd_row)), 64'd1);
            chk("read_after_fresh_done", 64'(done_fresh), 64'd1);
            rd_row++;
         end
         if (ntt_start) begin
            chk("start_after_all_writes", 64'(wr_row), 64'(RW));
            chk("start_pulse_len", 64'(prev_st), 64'd0);
            start_cnt++;
         end
         if (busy) chk("mod_idx_stable", 64'(ntt_mod_idx), 64'(cur_mod));
         if (pend_idle) begin
            chk("busy_drop_after_last", 64'(busy), 64'd0);
            pend_idle = 0;
         end
         if (hold_pend) begin
            chk("m_hold_valid", 64'(m_valid), 64'd1);
            chk("m_hold_data", 64'(m_data), 64'(hold_data));
            hold_pend = 0;
         end
         if (m_valid && m_ready) begin
            chk("scoreboard_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e_pop = exp_q.pop_front();
               chk("m_data", 64'(m_data), 64'(e_pop.data));
               chk("m_last", 64'(m_last), 64'(e_pop.last));
            end
            if (m_last) begin
               last_cnt++;
               pend_idle = 1;
            end
            out_beats++;
         end else if (m_valid) begin
            hold_pend = 1;
            hold_data = m_data;
         end
      end
      prev_wr = ntt_mem_write;
      prev_rd = ntt_mem_read;
      prev_st = ntt_start;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
      chk({tag, "_m_last"}, 64'(m_last), 64'd0);
      chk({tag, "_m_data"}, 64'(m_data), 64'd0);
      chk({tag, "_start"}, 64'(ntt_start), 64'd0);
      chk({tag, "_mem_write"}, 64'(ntt_mem_write), 64'd0);
      chk({tag, "_mem_read"}, 64'(ntt_mem_read), 64'd0);
      chk({tag, "_addr_zero"}, 64'(ntt_mem_addr === '0), 64'd1);
      chk({tag, "_din_zero"}, 64'(ntt_din === '0), 64'd1);
      chk({tag, "_mod_idx"}, 64'(ntt_mod_idx), 64'd0);
   endtask

   task automatic run_job(input int job, input logic [MOD_W-1:0] mod, input bit rv, input bit rr,
                          input bit hold, input bit go_in_wait, input bit reset_mid);
      int i;
      int guard;
      exp_t e;
      rand_ready = rr;
      done_hold  = hold;
      @(posedge clk); #1;
      wr_row = 0; rd_row = 0; start_cnt = 0; last_cnt = 0; out_beats = 0;
      cur_mod = mod;
      go = 1'b1;
      mod_idx_in = mod;
      @(posedge clk); #1;
      go = 1'b0;
      mod_idx_in = '0;
      chk("busy_after_go", 64'(busy), 64'd1);
      chk("ready_in_load", 64'(s_ready), 64'd1);
      i = 0;
      guard = 0;
      while (i < N && guard < 8 * N) begin
         s_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
         s_data  = data_of(job, i);
         @(negedge clk);
         if (s_valid && s_ready) begin
            e.data = inc_mod(s_data);
            e.last = (i == N - 1);
            exp_q.push_back(e);
            i++;
         end
         @(posedge clk); #1;
         guard++;
      end
      s_valid = 1'b0;
      chk("all_words_accepted", 64'(i), 64'(N));

      if (go_in_wait) begin
         guard = 0;
         while (start_cnt == 0 && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         chk("start_seen", 64'(start_cnt), 64'd1);
         repeat (3) @(posedge clk);
         #1;
         go = 1'b1;
         mod_idx_in = 6'd5;
         @(posedge clk); #1;
         go = 1'b0;
         mod_idx_in = '0;
      end

      if (reset_mid) begin
         guard = 0;
         while (out_beats < 4 * LN + 100 && guard < 20 * N) begin
            @(negedge clk);
            guard++;
         end
         chk("reached_row4_drain", 64'(out_beats >= 4 * LN + 100), 64'd1);
         @(posedge clk);
         #2;
         reset_n = 1'b0;
         #1;
         check_outputs_zero("midreset");
         repeat (3) @(posedge clk);
         #1;
         reset_n = 1'b1;
         exp_q.delete();
         pend_idle = 0;
         hold_pend = 0;
         return;
      end

      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (busy && guard < 20 * N);
      chk("job_finished", 64'(busy), 64'd0);
      chk("write_pulses", 64'(wr_row), 64'(RW));
      chk("start_pulses", 64'(start_cnt), 64'd1);
      chk("read_rows", 64'(rd_row), 64'(RW));
      chk("m_last_count", 64'(last_cnt), 64'd1);
      chk("output_beats", 64'(out_beats), 64'(N));
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      if (go_in_wait) begin
         repeat (5) @(negedge clk);
         chk("go_in_wait_not_queued", 64'(busy), 64'd0);
         chk("mod_kept_after_ignored_go", 64'(ntt_mod_idx), 64'd1);
      end
   endtask

   initial begin
      #3;
      check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      s_valid = 1'b1;
      s_data  = 32'h0000_0055;
      @(negedge clk);
      chk("idle_no_ready", 64'(s_ready), 64'd0);
      chk("idle_not_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      s_valid = 1'b0;

      run_job(1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_job(2, 6'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_job(3, 6'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      run_job(4, 6'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      run_job(5, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #700000;
      $display("FAIL watchdog: simulation time limit reached, tests %0d failures %0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
